tick_ctrl: RTL and testbench

- Run/pause/stop controller and programmable prescaler for the board's 48 MHz clock.
- Produces a one-cycle tick enable per period, a square-wave output and a tick counter, for stopwatch/display logic.
- Divisor is reconfigurable at run time via a load/ack handshake. A new divisor takes effect only on a period boundary, so no runt periods occur.

---
 rtl/tick_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tick_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_ctrl.sv
// tick_ctrl: run/pause/stop prescaler; tick, clk_out, div_ack, div_err are registered (1-cycle latency), no backpressure.
// Define TICK_ONESHOT_EN to add the oneshot input (start from IDLE runs a single period).
module tick_ctrl #(
   parameter int          DIV_W       = 32,
   parameter int unsigned DEFAULT_DIV = 48000000,
   parameter int          CNT_W       = 16
) (
   input  logic             clk_48MHZ,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
`ifdef TICK_ONESHOT_EN
   input  logic             oneshot,
`endif
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic             tick,
   output logic             clk_out,
   output logic             running,
   output logic [CNT_W-1:0] tick_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

   logic [1:0]       state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [DIV_W-1:0] div_cur, div_n;
   logic [DIV_W-1:0] pend_val, pend_val_n;
   logic             pend_vld, pend_vld_n;
   logic [CNT_W-1:0] tick_cnt_n;
   logic             tick_n;
   logic             boundary;
   logic             apply;
   logic             load_ok;
   logic             last;
`ifdef TICK_ONESHOT_EN
   logic             os_flag, os_n;
`endif

   assign last    = (cnt == div_cur - 1'b1);
   assign load_ok = div_load && (div_val >= MIN_DIV);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      tick_n     = 1'b0;
      tick_cnt_n = tick_cnt;
      boundary   = 1'b0;
`ifdef TICK_ONESHOT_EN
      os_n       = os_flag;
`endif
      if (clear) begin
         // clear outranks a wrap in the same cycle: no tick, counters restart
         cnt_n      = '0;
         tick_cnt_n = '0;
         boundary   = 1'b1;
      end else if (stop) begin
         if (state == S_RUN) begin
            state_n = S_PAUSE;
         end else if (state == S_PAUSE) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            boundary = 1'b1;
`ifdef TICK_ONESHOT_EN
            os_n     = 1'b0;
`endif
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_n = S_RUN;
`ifdef TICK_ONESHOT_EN
                  os_n    = oneshot;
`endif
               end
            end
            S_RUN: begin
               if (last) begin
                  cnt_n      = '0;
                  tick_n     = 1'b1;
                  tick_cnt_n = tick_cnt + 1'b1;
                  boundary   = 1'b1;
`ifdef TICK_ONESHOT_EN
                  if (os_flag) begin
                     state_n = S_IDLE;
                     os_n    = 1'b0;
                  end
`endif
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_PAUSE: begin
               if (start) state_n = S_RUN;
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // A pending divisor only lands on a period boundary, or at once while idle.
   always_comb begin
      apply      = pend_vld && (boundary || (state == S_IDLE));
      div_n      = div_cur;
      pend_vld_n = pend_vld;
      pend_val_n = pend_val;
      if (apply) begin
         div_n      = pend_val;
         pend_vld_n = 1'b0;
      end
      if (load_ok) begin
         pend_vld_n = 1'b1;
         pend_val_n = div_val;
      end
   end

   always_ff @(posedge clk_48MHZ) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         div_cur  <= DEF_DIV;
         pend_vld <= 1'b0;
         pend_val <= '0;
         tick     <= 1'b0;
         div_ack  <= 1'b0;
         div_err  <= 1'b0;
         clk_out  <= 1'b0;
         running  <= 1'b0;
         tick_cnt <= '0;
`ifdef TICK_ONESHOT_EN
         os_flag  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_cur  <= div_n;
         pend_vld <= pend_vld_n;
         pend_val <= pend_val_n;
         tick     <= tick_n;
         div_ack  <= apply;
         div_err  <= div_load && !load_ok;
         clk_out  <= (state_n != S_IDLE) && (cnt_n < (div_n >> 1));
         running  <= (state_n == S_RUN);
         tick_cnt <= tick_cnt_n;
`ifdef TICK_ONESHOT_EN
         os_flag  <= os_n;
`endif
      end
   end

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl (DEFAULT_DIV=4, CNT_W=2) with a per-cycle reference model.
module tb_tick_ctrl;

   localparam int DIV_W = 32;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst, start, stop, clear, div_load;
   logic [DIV_W-1:0] div_val;
   logic             div_ack, div_err, tick, clk_out, running;
   logic [CNT_W-1:0] tick_cnt;
`ifdef TICK_ONESHOT_EN
   logic             oneshot;
`endif

   int total = 0;
   int passed = 0;

   tick_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(4), .CNT_W(CNT_W)) dut (
      .clk_48MHZ(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .clear(clear),
`ifdef TICK_ONESHOT_EN
      .oneshot(oneshot),
`endif
      .div_load(div_load),
      .div_val(div_val),
      .div_ack(div_ack),
      .div_err(div_err),
      .tick(tick),
      .clk_out(clk_out),
      .running(running),
      .tick_cnt(tick_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: mode 0=idle 1=run 2=pause, pos = position within the period.
   int          m_mode, e_tcnt;
   int unsigned m_pos, m_div, m_pend;
   bit          m_has_pend, m_os, m_valid = 1'b0;
   bit          e_tick, e_ack, e_err, e_clk, e_run;

   always @(posedge clk) begin : model
      bit boundary;
      int old_mode;
      e_tick = 1'b0;
      e_ack  = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
         m_valid = 1'b1; m_mode = 0; m_pos = 0; m_div = 4;
         m_has_pend = 1'b0; m_os = 1'b0; e_tcnt = 0;
      end else begin
         boundary = 1'b0;
         old_mode = m_mode;
         if (clear) begin
            m_pos = 0; e_tcnt = 0; boundary = 1'b1;
         end else if (stop) begin
            if (m_mode == 1) m_mode = 2;
            else if (m_mode == 2) begin
               m_mode = 0; m_pos = 0; m_os = 1'b0; boundary = 1'b1;
            end
         end else if (m_mode == 1) begin
            m_pos = m_pos + 1;
            if (m_pos == m_div) begin
               m_pos = 0; e_tick = 1'b1; boundary = 1'b1;
               e_tcnt = (e_tcnt + 1) % (1 << CNT_W);
               if (m_os) begin m_mode = 0; m_os = 1'b0; end
            end
         end else if (start) begin
`ifdef TICK_ONESHOT_EN
            if (m_mode == 0) m_os = oneshot;
`endif
            m_mode = 1;
         end
         if (old_mode == 0) boundary = 1'b1;
         if (boundary && m_has_pend) begin
            m_div = m_pend; m_has_pend = 1'b0; e_ack = 1'b1;
         end
         if (div_load) begin
            if (div_val < 2) e_err = 1'b1;
            else begin m_pend = div_val; m_has_pend = 1'b1; end
         end
      end
      e_run = (m_mode == 1);
      e_clk = (m_mode != 0) && (m_pos < m_div / 2);
   end

   always @(negedge clk) begin
      if (m_valid)
         check("cycle{tick,ack,err,clk,run,cnt}",
               32'({tick, div_ack, div_err, clk_out, running, tick_cnt}),
               32'({e_tick, e_ack, e_err, e_clk, e_run, 2'(e_tcnt)}));
   end

   task automatic nx();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      div_load = 1'b0; div_val = '0;
`ifdef TICK_ONESHOT_EN
      oneshot = 1'b0;
`endif
      repeat (2) nx();
      check("reset_outputs", 32'({tick, div_ack, div_err, clk_out, running, tick_cnt}), 32'd0);

      // free run, start held: tick every 4, clk_out 1,1,0,0, tick_cnt wraps at 4
      rst = 1'b0; start = 1'b1;
      for (int j = 0; j <= 20; j++) begin
         nx();
         check("run_tick", 32'(tick), 32'(j > 0 && j % 4 == 0));
         check("run_clk", 32'(clk_out), 32'((j % 4) < 2));
         check("run_tick_cnt", 32'(tick_cnt), 32'((j / 4) % 4));
      end
      start = 1'b0;

      // pause at cnt=2, resume, tick two cycles later
      nx(); nx();
      stop = 1'b1; nx(); stop = 1'b0;
      check("pause_running", 32'(running), 32'd0);
      check("pause_clk", 32'(clk_out), 32'd0);
      for (int k = 0; k < 10; k++) begin
         nx();
         check("pause_no_tick", 32'(tick), 32'd0);
      end
      start = 1'b1; nx(); start = 1'b0;
      check("resume_running", 32'(running), 32'd1);
      nx();
      check("resume_tick_early", 32'(tick), 32'd0);
      nx();
      check("resume_tick", 32'(tick), 32'd1);
      stop = 1'b1; nx(); nx(); stop = 1'b0;
      check("stop_idle_running", 32'(running), 32'd0);
      check("stop_idle_clk", 32'(clk_out), 32'd0);

      // start+stop together while running: stop wins
      start = 1'b1; nx();
      stop = 1'b1; nx();
      check("start_stop_pause", 32'(running), 32'd0);
      start = 1'b0; nx(); stop = 1'b0;

      // divisor 6 loaded at cnt=1: current period finishes, then 6-cycle periods
      start = 1'b1; nx(); start = 1'b0;
      nx();
      div_load = 1'b1; div_val = 6; nx(); div_load = 1'b0;
      nx();
      check("load_no_early_ack", 32'(div_ack), 32'd0);
      nx();
      check("load_wrap_tick", 32'(tick), 32'd1);
      check("load_ack", 32'(div_ack), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         nx();
         check("period6_tick", 32'(tick), 32'(k == 6));
      end
      div_load = 1'b1; div_val = 1; nx(); div_load = 1'b0;
      check("div_err_pulse", 32'(div_err), 32'd1);
      nx();
      check("div_err_single", 32'(div_err), 32'd0);
      repeat (4) nx();
      check("period6_kept", 32'(tick), 32'd1);

      // two loads in one period: single ack, last value wins
      div_load = 1'b1; div_val = 5; nx();
      div_val = 7; nx(); div_load = 1'b0;
      repeat (4) nx();
      check("dbl_wrap_tick", 32'(tick), 32'd1);
      check("dbl_ack", 32'(div_ack), 32'd1);
      for (int k = 1; k <= 14; k++) begin
         nx();
         check("period7_tick", 32'(tick), 32'(k % 7 == 0));
         check("period7_no_ack", 32'(div_ack), 32'd0);
      end

      // clear at the last count of a period
      repeat (6) nx();
      clear = 1'b1; nx(); clear = 1'b0;
      check("clear_no_tick", 32'(tick), 32'd0);
      check("clear_tick_cnt", 32'(tick_cnt), 32'd0);
      repeat (7) nx();
      check("after_clear_tick", 32'(tick), 32'd1);
      check("after_clear_cnt", 32'(tick_cnt), 32'd1);

      // reset with a divisor pending: pending value discarded
      div_load = 1'b1; div_val = 9; nx(); div_load = 1'b0;
      nx();
      rst = 1'b1; nx(); rst = 1'b0;
      check("rst_mid_outputs", 32'({tick, div_ack, div_err, clk_out, running, tick_cnt}), 32'd0);
      start = 1'b1; nx(); start = 1'b0;
      repeat (4) nx();
      check("rst_default_div_tick", 32'(tick), 32'd1);
      check("rst_no_stale_ack", 32'(div_ack), 32'd0);

`ifdef TICK_ONESHOT_EN
      stop = 1'b1; nx(); nx(); stop = 1'b0;
      start = 1'b1; oneshot = 1'b1; nx(); start = 1'b0; oneshot = 1'b0;
      repeat (4) nx();
      check("oneshot_tick", 32'(tick), 32'd1);
      check("oneshot_idle", 32'(running), 32'd0);
      check("oneshot_clk", 32'(clk_out), 32'd0);
      for (int k = 0; k < 8; k++) begin
         nx();
         check("oneshot_no_more", 32'(tick), 32'd0);
      end
`endif

      repeat (3) nx();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
